// File: rtl/sha512_pkg.sv
// rtl/sha512_pkg.sv - shared SHA-512 constants, state encoding and round helpers
package sha512_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam logic [63:0] PAD_WORD = {PAD_BYTE, 56'h0};

    localparam logic [511:0] H_0 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [63:0] K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef enum logic [1:0] {FILL, START, WAIT} state_t;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

endpackage

// File: rtl/sha512_block.sv
// rtl/sha512_block.sv - one SHA-512 compression, one round per cycle, no reset
module sha512_block
    import sha512_pkg::*;
(
    input  logic          clk,
    input  logic          input_valid,
    input  logic [511:0]  H_in,
    input  logic [1023:0] M_in,
    output logic          output_valid,
    output logic [511:0]  H_out
);

    logic [63:0] st [8];
    logic [63:0] nx [8];
    logic [63:0] w [16];
    logic [6:0]  rnd;
    logic [63:0] t1, t2, w_new, k_t;

    always_comb begin
        k_t   = (rnd < 7'd80) ? K[rnd] : 64'h0;
        t1    = st[7] + big_sigma1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k_t + w[0];
        t2    = big_sigma0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        nx[0] = t1 + t2;
        nx[1] = st[0];
        nx[2] = st[1];
        nx[3] = st[2];
        nx[4] = st[3] + t1;
        nx[5] = st[4];
        nx[6] = st[5];
        nx[7] = st[6];
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    // Round 79 is folded into the output adders so the result is ready 80 cycles after load.
    assign output_valid = (rnd == 7'd79);

    for (genvar i = 0; i < 8; i++) begin : g_out
        assign H_out[511-64*i -: 64] = H_in[511-64*i -: 64] + nx[i];
    end

    always_ff @(posedge clk) begin
        if (input_valid) begin
            for (int i = 0; i < 8; i++) st[i] <= H_in[511-64*i -: 64];
            for (int i = 0; i < 16; i++) w[i] <= M_in[1023-64*i -: 64];
            rnd <= 7'd0;
        end else begin
            for (int i = 0; i < 8; i++) st[i] <= nx[i];
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
            rnd   <= (rnd == 7'd79) ? 7'd0 : rnd + 7'd1;
        end
    end

endmodule

// File: rtl/sha512_stream.sv
// rtl/sha512_stream.sv - message padding, block sequencing and digest chaining for SHA-512
module sha512_stream
    import sha512_pkg::*;
#(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [3:0]   s_bytes,
    output logic [511:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    state_t             state;
    logic [63:0]        blk_q [BLOCK_WORDS];
    logic [511:0]       h_q;
    logic [3:0]         widx;
    logic [LEN_W-1:0]   byte_cnt;
    logic               pad2, mark2, final_blk;

    logic               input_valid, output_valid;
    logic [511:0]       h_out;
    logic [1023:0]      m_in;

    logic [LEN_W-1:0]   len_new;
    logic [127:0]       len_new_bits, len_cur_bits;
    logic [63:0]        last_word;
    logic               b8, pad_final;
    logic [4:0]         f_idx;
    logic [63:0]        pad_blk [BLOCK_WORDS];
    logic [63:0]        tail_blk [BLOCK_WORDS];

    assign s_ready     = !rst && (state == FILL);
    assign input_valid = (state == START);

    for (genvar j = 0; j < BLOCK_WORDS; j++) begin : g_min
        assign m_in[1023-64*j -: 64] = blk_q[j];
    end

    // Block image produced when the last word of a message is accepted.
    always_comb begin
        len_new      = byte_cnt + LEN_W'(s_bytes);
        len_new_bits = 128'({len_new, 3'b000});
        b8           = (s_bytes == 4'd8);
        last_word    = 64'h0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(s_bytes))
                last_word[63-8*k -: 8] = s_data[63-8*k -: 8];
            else if (k == int'(s_bytes))
                last_word[63-8*k -: 8] = PAD_BYTE;
        end
        f_idx     = {1'b0, widx} + (b8 ? 5'd2 : 5'd1);
        pad_final = (f_idx <= 5'd14);
        for (int j = 0; j < BLOCK_WORDS; j++) begin
            if (j < int'(widx))
                pad_blk[j] = blk_q[j];
            else if (j == int'(widx))
                pad_blk[j] = last_word;
            else if (b8 && (j == int'(widx) + 1))
                pad_blk[j] = PAD_WORD;
            else
                pad_blk[j] = 64'h0;
        end
        if (pad_final) begin
            pad_blk[14] = len_new_bits[127:64];
            pad_blk[15] = len_new_bits[63:0];
        end
    end

    // Extra block when padding and length spill past the current one.
    always_comb begin
        len_cur_bits = 128'({byte_cnt, 3'b000});
        for (int j = 0; j < BLOCK_WORDS; j++) tail_blk[j] = 64'h0;
        tail_blk[0]  = mark2 ? PAD_WORD : 64'h0;
        tail_blk[14] = len_cur_bits[127:64];
        tail_blk[15] = len_cur_bits[63:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            h_q          <= H_0;
            widx         <= 4'd0;
            byte_cnt     <= '0;
            pad2         <= 1'b0;
            mark2        <= 1'b0;
            final_blk    <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (s_valid) begin
                        busy <= 1'b1;
                        if (!s_last) begin
                            blk_q[widx] <= s_data;
                            byte_cnt    <= byte_cnt + LEN_W'(8);
                            widx        <= widx + 4'd1;
                            if (widx == 4'd15) begin
                                final_blk <= 1'b0;
                                state     <= START;
                            end
                        end else begin
                            for (int j = 0; j < BLOCK_WORDS; j++) blk_q[j] <= pad_blk[j];
                            byte_cnt  <= len_new;
                            final_blk <= pad_final;
                            pad2      <= !pad_final;
                            mark2     <= b8 && (widx == 4'd15);
                            state     <= START;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (output_valid) begin
                        h_q <= h_out;
                        if (final_blk) begin
                            digest       <= h_out;
                            digest_valid <= 1'b1;
                            busy         <= 1'b0;
                            h_q          <= H_0;
                            byte_cnt     <= '0;
                            widx         <= 4'd0;
                            pad2         <= 1'b0;
                            mark2        <= 1'b0;
                            final_blk    <= 1'b0;
                            state        <= FILL;
                        end else if (pad2) begin
                            for (int j = 0; j < BLOCK_WORDS; j++) blk_q[j] <= tail_blk[j];
                            final_blk <= 1'b1;
                            pad2      <= 1'b0;
                            state     <= START;
                        end else begin
                            widx  <= 4'd0;
                            state <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    sha512_block u_block (
        .clk          (clk),
        .input_valid  (input_valid),
        .H_in         (h_q),
        .M_in         (m_in),
        .output_valid (output_valid),
        .H_out        (h_out)
    );

endmodule
